rob_host_arb: RTL
=================

ROB_HOST_ARB -- requirements
Module: rob_host_arb

Interface
REQ-001 SHALL have parameter NUM_HOST, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter AW, default 32, request address width.
REQ-003 SHALL have parameter DW, default 32, response data width.
REQ-004 SHALL have parameter IW, default 4, per-host transaction id width.
REQ-005 SHALL have parameter DEPTH, default 8, max outstanding transactions (power of 2).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 req_valid  in  NUM_HOST  per-host request valid.
REQ-009 req_ready  out  NUM_HOST  per-host request accept.
REQ-010 req_addr  in  NUM_HOST*AW  per-host address, host i in slice [i*AW +: AW].
REQ-011 req_id  in  NUM_HOST*IW  per-host id, host i in slice [i*IW +: IW].
REQ-012 rob_req_valid  out  1  request to ROB host port, registered.
REQ-013 rob_req_ready  in  1  ROB request accept.
REQ-014 rob_req_addr  out  AW  registered address.
REQ-015 rob_req_id  out  IW+clog2(NUM_HOST)  {host index, host id}, registered.
REQ-016 rob_rsp_valid  in  1  in-order response from ROB.
REQ-017 rob_rsp_ready  out  1  response accept to ROB.
REQ-018 rob_rsp_data  in  DW  response data.
REQ-019 rob_rsp_id  in  IW+clog2(NUM_HOST)  echoed id.
REQ-020 rsp_valid  out  NUM_HOST  per-host response valid.
REQ-021 rsp_ready  in  NUM_HOST  per-host response accept.
REQ-022 rsp_data  out  DW  response data, shared by all hosts.
REQ-023 rsp_id  out  IW  low IW bits of rob_rsp_id.
REQ-024 outstanding  out  clog2(DEPTH)+1  issued-not-returned count.
REQ-025 err_unexp  out  1  sticky: response arrived with route FIFO empty.

Function
REQ-026 Output stage SHALL load when (!rob_req_valid || rob_req_ready) && any req_valid && outstanding < DEPTH; loading is called "issue".
REQ-027 On issue, exactly one req_ready bit (the grantee) SHALL be 1; all others 0; no req_ready when not issuing.
REQ-028 Grantee SHALL be round-robin: first requesting host at or after rr_ptr, wrapping NUM_HOST-1 -> 0.
REQ-029 After issue to host g, rr_ptr SHALL become (g+1) mod NUM_HOST; unchanged otherwise.
REQ-030 Issue latency SHALL be 1 cycle: rob_req_valid/addr/id reflect the grantee's inputs on the cycle after the handshake.
REQ-031 rob_req_valid SHALL clear when rob_req_ready=1 and no new issue; outputs SHALL hold stable while rob_req_valid && !rob_req_ready.
REQ-032 On issue, grantee index SHALL be pushed into route FIFO (DEPTH entries); outstanding increments.
REQ-033 Route FIFO head h SHALL drive rsp_valid[h]=rob_rsp_valid; other rsp_valid bits 0; rob_rsp_ready=rsp_ready[h].
REQ-034 Response handshake (rob_rsp_valid && rob_rsp_ready) SHALL pop FIFO; outstanding decrements.
REQ-035 Simultaneous issue and pop SHALL leave outstanding unchanged; full check uses pre-pop count (no pop-to-issue comb path).
REQ-036 FIFO empty SHALL force rob_rsp_ready=0, all rsp_valid=0; rob_rsp_valid then SHALL set err_unexp.
REQ-037 Routing SHALL use FIFO head only; rob_rsp_id high bits are not checked.
REQ-038 Host request blocked by arbitration SHALL see req_ready=0 and keep its request (no drop).

Reset
REQ-039 On rst=1 at a clock edge: rob_req_valid=0, rob_req_addr=0, rob_req_id=0, rr_ptr=0, FIFO empty, outstanding=0, err_unexp=0.
REQ-040 During rst, req_ready=0, rsp_valid=0, rob_rsp_ready=0; reset mid-operation discards all in-flight state.

Verification
REQ-041 All 4 hosts valid continuously, rob_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; ids carry host index.
REQ-042 Host 2 only, rob_req_ready=0 for 5 cycles -> one issue, rob_req_valid/addr held 5 cycles, req_ready[2]=0 meanwhile.
REQ-043 Issue 8 with no responses -> outstanding=8, no req_ready; one response pops -> next cycle issue resumes.
REQ-044 Issue hosts 1,3,0; ROB returns 3 responses; rsp_ready[3]=0 on second -> rsp_valid[1], then rsp_valid[3] stalls with rob_rsp_ready=0 until released, then rsp_valid[0].
REQ-045 rob_rsp_valid=1 with outstanding=0 -> err_unexp=1 next cycle, stays 1 until rst.
REQ-046 rst asserted with outstanding=5, rob_req_valid=1 -> next cycle all outputs at reset values, rr_ptr=0.

Source files
------------

// File: rtl/rob_host_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rob_host_arb
//  Description : Round-robin arbiter funnelling host requests into one ROB
//                port, routing in-order ROB responses back via a route FIFO.
//  Revision    : 1.0
// ============================================================================
module rob_host_arb #(
    parameter int NUM_HOST = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int IW       = 4,
    parameter int DEPTH    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_HOST-1:0]                 req_valid,
    output logic [NUM_HOST-1:0]                 req_ready,
    input  logic [NUM_HOST*AW-1:0]              req_addr,
    input  logic [NUM_HOST*IW-1:0]              req_id,
    output logic                                rob_req_valid,
    input  logic                                rob_req_ready,
    output logic [AW-1:0]                       rob_req_addr,
    output logic [IW+$clog2(NUM_HOST)-1:0]      rob_req_id,
    input  logic                                rob_rsp_valid,
    output logic                                rob_rsp_ready,
    input  logic [DW-1:0]                       rob_rsp_data,
    input  logic [IW+$clog2(NUM_HOST)-1:0]      rob_rsp_id,
    output logic [NUM_HOST-1:0]                 rsp_valid,
    input  logic [NUM_HOST-1:0]                 rsp_ready,
    output logic [DW-1:0]                       rsp_data,
    output logic [IW-1:0]                       rsp_id,
    output logic [$clog2(DEPTH):0]              outstanding,
    output logic                                err_unexp
);

    localparam int HW  = $clog2(NUM_HOST);
    localparam int HW1 = HW + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int OW  = PW + 1;

    localparam logic [OW-1:0]  c_DEPTH = OW'(DEPTH);
    localparam logic [HW:0]    c_NUM   = HW1'(NUM_HOST);
    localparam logic [HW-1:0]  c_LAST  = HW'(NUM_HOST - 1);

    logic                 r_rob_req_valid;
    logic [AW-1:0]        r_rob_req_addr;
    logic [IW+HW-1:0]     r_rob_req_id;
    logic [HW-1:0]        r_rr_ptr;
    logic [HW-1:0]        r_route [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [OW-1:0]        r_outstanding;
    logic                 r_err_unexp;

    logic [2*NUM_HOST-1:0] w_dbl;
    logic [NUM_HOST-1:0]   w_rot;
    logic [HW-1:0]         w_off;
    logic [HW:0]           w_sum;
    logic [HW:0]           w_sum_wrap;
    logic [HW-1:0]         w_grant;
    logic                  w_issue;
    logic [AW-1:0]         w_sel_addr;
    logic [IW-1:0]         w_sel_id;
    logic                  w_empty;
    logic [HW-1:0]         w_head;
    logic                  w_pop;

    // Rotate requests so bit 0 is the host at rr_ptr; lowest set bit wins.
    assign w_dbl = {req_valid, req_valid} >> r_rr_ptr;
    assign w_rot = w_dbl[NUM_HOST-1:0];

    always_comb begin
        w_off = '0;
        for (int i = NUM_HOST - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = HW'(i);
            end
        end
    end

    assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_sum_wrap = w_sum - c_NUM;
    assign w_grant    = (w_sum >= c_NUM) ? w_sum_wrap[HW-1:0] : w_sum[HW-1:0];

    // Full check uses the registered count so a pop never feeds issue combinationally.
    assign w_issue = !rst && (!r_rob_req_valid || rob_req_ready) &&
                     (|req_valid) && (r_outstanding < c_DEPTH);

    always_comb begin
        w_sel_addr = '0;
        w_sel_id   = '0;
        for (int i = 0; i < NUM_HOST; i++) begin
            if (w_grant == HW'(i)) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_id   = req_id[i*IW +: IW];
            end
        end
    end

    assign req_ready = w_issue ? (NUM_HOST'(1) << w_grant) : '0;

    assign w_empty = (r_outstanding == '0);
    assign w_head  = r_route[r_rd_ptr];

    assign rob_rsp_ready = !rst && !w_empty && rsp_ready[w_head];
    assign rsp_valid     = (!rst && !w_empty && rob_rsp_valid) ? (NUM_HOST'(1) << w_head) : '0;
    assign w_pop         = rob_rsp_valid && rob_rsp_ready;
    assign rsp_data      = rob_rsp_data;
    assign rsp_id        = rob_rsp_id[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rob_req_valid <= 1'b0;
            r_rob_req_addr  <= '0;
            r_rob_req_id    <= '0;
            r_rr_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_outstanding   <= '0;
            r_err_unexp     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rob_req_valid <= 1'b1;
                r_rob_req_addr  <= w_sel_addr;
                r_rob_req_id    <= {w_grant, w_sel_id};
                r_rr_ptr        <= (w_grant == c_LAST) ? '0 : w_grant + 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end else if (rob_req_ready) begin
                r_rob_req_valid <= 1'b0;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_issue, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (rob_rsp_valid && w_empty) begin
                r_err_unexp <= 1'b1;
            end
        end
    end

    // Route storage holds only data; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_route[r_wr_ptr] <= w_grant;
        end
    end

    assign rob_req_valid = r_rob_req_valid;
    assign rob_req_addr  = r_rob_req_addr;
    assign rob_req_id    = r_rob_req_id;
    assign outstanding   = r_outstanding;
    assign err_unexp     = r_err_unexp;

endmodule
`default_nettype wire
